xmpl_cic_int: RTL and testbench
===============================

Name: xmpl_cic_int

Overview:
CIC interpolator for the DSP core. It is the transmit-side counterpart of the decimating CIC.
- Accepts low-rate signed samples over a valid/ready handshake.
- Runs N comb stages at the low rate, then zero-stuffs by R, then runs N integrators at the high rate.
- Emits one signed full-precision output per high-rate step.
- Sits between the baseband sample source and the DAC/upconverter path.

Parameters:
- IN_W, 12, input sample width (signed two's complement)
- N_STAGES, 3, number of comb stages and integrator stages (differential delay M fixed at 1)
- R_LOG2, 3, log2 of interpolation ratio R (R = 8)
- OUT_W, IN_W + (N_STAGES-1)*R_LOG2 = 18, internal and output width, full precision

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- en_cic_i  in  1  block enable; low flushes state
- cic_x_i  in  IN_W  input sample, signed
- cic_x_valid_i  in  1  input sample valid
- cic_x_ready_o  out  1  block accepts a sample this cycle
- cic_y_o  out  OUT_W  output sample, signed
- cic_y_valid_o  out  1  output strobe, one per step
- cic_underrun_o  out  1  sticky: input absent when a new sample was required

Behaviour:
- Reset and port naming (decided): one clock clk_i; reset_i is synchronous and active-high.
- Reset (reset_i=1 at a clk_i edge) clears:
  - all comb delay regs, the zero-stuff reg x_up, and all integrators
  - phase counter (R_LOG2 bits) to 0, FSM to IDLE
  - outputs: cic_y_o=0, cic_y_valid_o=0, cic_x_ready_o=0, cic_underrun_o=0
  - reset has priority over everything, including mid-operation.
- FSM states:
  - IDLE: cic_x_ready_o=0; goes to RUN on the cycle en_cic_i=1 is seen.
  - RUN: active operation.
  - From RUN, en_cic_i=0 returns to IDLE next cycle and clears all datapath state, phase and underrun. This is identical to reset, except it is gated by enable.
- In RUN:
  - cic_x_ready_o = (phase==0), combinational from registered state.
  - step = (phase!=0) | (phase==0 & cic_x_valid_i). No step means no state change and cic_y_valid_o=0 that cycle.
  - At phase 0 with cic_x_valid_i=0: stall, and set cic_underrun_o (sticky until reset or disable).
- Comb chain (low rate, updated only on accept = step & phase==0):
  - c0 = sign-extended cic_x_i to OUT_W
  - c_k = c_{k-1} - d_k
  - d_k <= c_{k-1}
  - The chain is combinational within the accept cycle.
- On each step:
  - x_up <= (phase==0) ? c_N : 0
  - i_1 <= i_1 + x_up
  - i_k <= i_k + i_{k-1}, using pre-step values
  - phase <= phase + 1, wrapping R-1 -> 0
  - cic_y_o <= i_N (new value)
  - cic_y_valid_o <= 1 for one cycle
- Arithmetic: all adders OUT_W-bit two's complement, wrap-around modulo 2^OUT_W (CIC wrap is benign). No saturation, no rounding.
- Gain and latency:
  - DC gain R^(N_STAGES-1) = 64; full-scale input -2048 gives -131072, exactly fitting OUT_W.
  - Latency: first non-zero output for an accepted sample appears on the (N_STAGES+1)th step after acceptance, counting the accept step as 1.
  - Impulse response length N*(R-1)+1 = 22 steps.
- Simultaneous events:
  - Reset with en_cic_i=1: reset wins, FSM in IDLE next cycle.
  - en_cic_i falling while cic_x_valid_i=1 at phase 0: no accept, flush.
  - A stall (phase 0, no valid) holds all integrator values unchanged.

Decomposition:
- Package xmpl_dsp_pkg:
  - localparam helper for OUT_W growth
  - typedef enum logic {IDLE, RUN} cic_int_state_e
  - typedef for the OUT_W signed sample type
- One natural sub-module: xmpl_cic_int_stage. It holds one comb plus one integrator with step/accept enables and is instantiated N_STAGES times in a generate loop.

Test Plan:
- Impulse: after reset, en=1, feed 1 then zeros (valid every phase 0) -> y steps give 1,3,6,10,15,21,28,36,... (22 non-zero values, sum 512, symmetric), then 0.
- DC: feed constant 100 -> after transient, every y = 6400; feed -2048 -> steady y = -131072, no wrap.
- Handshake and underrun: withhold valid at phase 0 for 5 cycles -> y_valid low those cycles, y and integrators frozen, underrun=1 and stays 1. Resume -> sequence continues exactly where it left off.
- Disable mid-stream: drop en_cic_i at phase 4 -> next cycle y_valid=0, ready=0, underrun=0. Re-enable and send an impulse -> response identical to the first test.
- Reset mid-operation: assert reset_i for 1 cycle during DC run -> all outputs 0 next cycle; after restart, first output matches a fresh impulse/DC transient.
- Random stimulus of 10k samples with random valid gaps -> outputs bit-exact against a golden model (numpy CIC with zero-stuff and mod-2^18 arithmetic), valid count = R × accepted samples.

Source files
------------

// File: rtl/xmpl_dsp_pkg.sv
// Shared DSP types and width helpers for the CIC blocks.
package xmpl_dsp_pkg;

  // Full-precision CIC interpolator width: input plus (N-1)*log2(R) bits of growth.
  function automatic int cic_out_w(input int in_w, input int n_stages, input int r_log2);
    return in_w + (n_stages - 1) * r_log2;
  endfunction

  localparam int CIC_IN_W     = 12;
  localparam int CIC_N_STAGES = 3;
  localparam int CIC_R_LOG2   = 3;
  localparam int CIC_OUT_W    = cic_out_w(CIC_IN_W, CIC_N_STAGES, CIC_R_LOG2);

  typedef enum logic {IDLE, RUN} cic_int_state_e;

  typedef logic signed [CIC_OUT_W-1:0] cic_sample_t;

endpackage

// File: rtl/xmpl_cic_int_stage.sv
// One CIC section: a comb (updated on accept) paired with an integrator (updated on step).
module xmpl_cic_int_stage #(
  parameter int W = 18
) (
  input  logic                clk,
  input  logic                clear,
  input  logic                accept,
  input  logic                step,
  input  logic signed [W-1:0] comb_x,
  output logic signed [W-1:0] comb_y,
  input  logic signed [W-1:0] integ_x,
  output logic signed [W-1:0] integ_q
);

  logic signed [W-1:0] d_q;

  assign comb_y = comb_x - d_q;

  always_ff @(posedge clk) begin
    if (clear) begin
      d_q     <= '0;
      integ_q <= '0;
    end else begin
      if (accept) d_q <= comb_x;
      if (step)   integ_q <= integ_q + integ_x;
    end
  end

endmodule

// File: rtl/xmpl_cic_int.sv
// CIC interpolator: N combs at the input rate, zero-stuff by R, N integrators at the output rate.
module xmpl_cic_int
  import xmpl_dsp_pkg::*;
#(
  parameter int IN_W     = 12,
  parameter int N_STAGES = 3,
  parameter int R_LOG2   = 3,
  parameter int OUT_W    = cic_out_w(IN_W, N_STAGES, R_LOG2)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    en_cic_i,
  input  logic [IN_W-1:0]         cic_x_i,
  input  logic                    cic_x_valid_i,
  output logic                    cic_x_ready_o,
  output logic signed [OUT_W-1:0] cic_y_o,
  output logic                    cic_y_valid_o,
  output logic                    cic_underrun_o
);

  cic_int_state_e state_q, state_d;

  logic [R_LOG2-1:0]       phase_q;
  logic signed [OUT_W-1:0] x_up_q;
  logic signed [OUT_W-1:0] comb_c [N_STAGES+1];
  logic signed [OUT_W-1:0] integ  [N_STAGES+1];
  logic signed [OUT_W-1:0] y_d;
  logic run, flush, clear, phase_zero, step, accept, stall;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en_cic_i)  state_d = RUN;
      RUN:     if (!en_cic_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Disable from RUN wipes the datapath exactly like reset does.
  assign run        = (state_q == RUN) & en_cic_i;
  assign flush      = (state_q == RUN) & ~en_cic_i;
  assign clear      = reset_i | flush;
  assign phase_zero = (phase_q == '0);
  assign step       = run & (~phase_zero | cic_x_valid_i);
  assign accept     = step & phase_zero;
  assign stall      = run & phase_zero & ~cic_x_valid_i;

  assign cic_x_ready_o = (state_q == RUN) & phase_zero;

  assign comb_c[0] = OUT_W'($signed(cic_x_i));
  assign integ[0]  = x_up_q;

  for (genvar k = 1; k <= N_STAGES; k++) begin : g_stage
    xmpl_cic_int_stage #(
      .W(OUT_W)
    ) u_stage (
      .clk     (clk_i),
      .clear   (clear),
      .accept  (accept),
      .step    (step),
      .comb_x  (comb_c[k-1]),
      .comb_y  (comb_c[k]),
      .integ_x (integ[k-1]),
      .integ_q (integ[k])
    );
  end

  // Output is the last integrator's post-step value, formed from pre-step operands.
  assign y_d = integ[N_STAGES] + integ[N_STAGES-1];

  always_ff @(posedge clk_i) begin
    if (clear) begin
      phase_q        <= '0;
      x_up_q         <= '0;
      cic_y_o        <= '0;
      cic_y_valid_o  <= 1'b0;
      cic_underrun_o <= 1'b0;
    end else begin
      cic_y_valid_o <= step;
      if (step) begin
        phase_q <= phase_q + 1'b1;
        x_up_q  <= phase_zero ? comb_c[N_STAGES] : '0;
        cic_y_o <= y_d;
      end
      if (stall) cic_underrun_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_xmpl_cic_int.sv
// Scoreboard bench for xmpl_cic_int: convolution reference model, decoupled output monitor.
module tb_xmpl_cic_int;

  localparam int IN_W  = 12;
  localparam int NS    = 3;
  localparam int RL    = 3;
  localparam int R     = 1 << RL;
  localparam int OUT_W = 18;
  localparam int HLEN  = NS * (R - 1) + 1;

  logic                    clk = 1'b0;
  logic                    reset_i = 1'b1;
  logic                    en_cic_i = 1'b0;
  logic [IN_W-1:0]         cic_x_i = '0;
  logic                    cic_x_valid_i = 1'b0;
  logic                    cic_x_ready_o;
  logic signed [OUT_W-1:0] cic_y_o;
  logic                    cic_y_valid_o;
  logic                    cic_underrun_o;

  xmpl_cic_int #(
    .IN_W    (IN_W),
    .N_STAGES(NS),
    .R_LOG2  (RL),
    .OUT_W   (OUT_W)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .en_cic_i      (en_cic_i),
    .cic_x_i       (cic_x_i),
    .cic_x_valid_i (cic_x_valid_i),
    .cic_x_ready_o (cic_x_ready_o),
    .cic_y_o       (cic_y_o),
    .cic_y_valid_o (cic_y_valid_o),
    .cic_underrun_o(cic_underrun_o)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state: zero-stuffed input history convolved with the CIC impulse response.
  longint h [HLEN];
  longint hist[$];
  longint exp_q[$];
  longint cap[$];
  bit     m_run = 1'b0;
  bit     m_und = 1'b0;
  int     m_n = 0;
  int     acc_cnt = 0;
  int     valid_cnt = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint wrap_out(input longint v);
    logic signed [OUT_W-1:0] t;
    t = v[OUT_W-1:0];
    return longint'(t);
  endfunction

  function automatic longint model_y(input int n);
    longint s = 0;
    for (int k = 0; k < HLEN; k++) begin
      int idx = n - NS - k;
      if (idx >= 0) s += h[k] * hist[idx];
    end
    return wrap_out(s);
  endfunction

  task automatic model_clear();
    m_run = 1'b0;
    m_n   = 0;
    m_und = 1'b0;
    hist.delete();
  endtask

  // One clock of stimulus; returns just after the following falling edge.
  task automatic drive(input bit rst, input bit en, input bit vld, input logic [IN_W-1:0] x);
    bit ph0;
    reset_i       = rst;
    en_cic_i      = en;
    cic_x_valid_i = vld;
    cic_x_i       = x;
    @(posedge clk);
    if (rst || (m_run && !en)) begin
      model_clear();
    end else if (!m_run) begin
      if (en) m_run = 1'b1;
    end else begin
      ph0 = (m_n % R) == 0;
      if (ph0 && !vld) begin
        m_und = 1'b1;
      end else begin
        hist.push_back(ph0 ? longint'($signed(x)) : 64'sd0);
        exp_q.push_back(model_y(m_n));
        if (ph0) acc_cnt++;
        m_n++;
      end
    end
    @(negedge clk);
    #1;
    chk("ready", cic_x_ready_o, m_run && ((m_n % R) == 0));
    chk("underrun", cic_underrun_o, m_und);
  endtask

  always @(negedge clk) begin
    if (cic_y_valid_o === 1'b1) begin
      valid_cnt++;
      cap.push_back(longint'(cic_y_o));
    end
    if (cic_y_valid_o === 1'b1 || exp_q.size() != 0) begin
      if (exp_q.size() == 0) chk("unexpected_y_valid", cic_y_valid_o, 0);
      else if (cic_y_valid_o !== 1'b1) begin
        chk("missing_y_valid", cic_y_valid_o, 1);
        void'(exp_q.pop_front());
      end else chk("y", cic_y_o, exp_q.pop_front());
    end
  end

  task automatic run_impulse();
    cap.delete();
    for (int i = 0; i < 40; i++) drive(0, 1, 1, (i == 0) ? 12'd1 : 12'd0);
  endtask

  task automatic check_impulse(input string tag);
    longint tbl [8] = '{1, 3, 6, 10, 15, 21, 28, 36};
    longint s = 0;
    chk({tag, "_pre"}, cap[NS-1], 0);
    for (int i = 0; i < 8; i++) chk({tag, "_tap"}, cap[NS+i], tbl[i]);
    for (int i = 0; i < HLEN; i++) s += cap[NS+i];
    chk({tag, "_sum"}, s, 512);
    chk({tag, "_sym"}, cap[NS+HLEN-1], cap[NS]);
    chk({tag, "_tail"}, cap[NS+HLEN], 0);
  endtask

  initial begin
    longint b2 [2*R-1];
    int cyc;
    b2 = '{default: 0};
    h  = '{default: 0};
    for (int i = 0; i < R; i++)
      for (int j = 0; j < R; j++) b2[i+j] += 1;
    for (int i = 0; i < 2*R-1; i++)
      for (int j = 0; j < R; j++) h[i+j] += b2[i];

    @(negedge clk);
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    chk("reset_y", cic_y_o, 0);
    chk("reset_y_valid", cic_y_valid_o, 0);
    chk("reset_ready", cic_x_ready_o, 0);
    chk("reset_underrun", cic_underrun_o, 0);

    drive(0, 1, 0, 0);
    run_impulse();
    check_impulse("impulse1");

    for (int i = 0; i < 64; i++) drive(0, 1, 1, 12'd100);
    chk("dc_100", cic_y_o, 6400);
    for (int i = 0; i < 64; i++) drive(0, 1, 1, 12'h800);
    chk("dc_fullscale", cic_y_o, -131072);

    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 0, 12'h123);
      chk("stall_y_valid", cic_y_valid_o, 0);
      chk("stall_y_frozen", cic_y_o, -131072);
    end
    chk("stall_underrun", cic_underrun_o, 1);
    for (int i = 0; i < 16; i++) drive(0, 1, 1, 12'h800);
    chk("resume_underrun_sticky", cic_underrun_o, 1);
    chk("resume_y", cic_y_o, -131072);

    for (int i = 0; i < 4; i++) drive(0, 1, 1, 12'h800);
    drive(0, 0, 1, 12'h800);
    chk("disable_y_valid", cic_y_valid_o, 0);
    chk("disable_ready", cic_x_ready_o, 0);
    chk("disable_underrun", cic_underrun_o, 0);
    drive(0, 1, 0, 0);
    run_impulse();
    check_impulse("impulse2");

    for (int i = 0; i < 30; i++) drive(0, 1, 1, 12'd100);
    drive(1, 1, 1, 12'd100);
    chk("midreset_y", cic_y_o, 0);
    chk("midreset_y_valid", cic_y_valid_o, 0);
    chk("midreset_ready", cic_x_ready_o, 0);
    chk("midreset_underrun", cic_underrun_o, 0);
    drive(0, 1, 0, 0);
    for (int i = 0; i < 40; i++) drive(0, 1, 1, 12'd100);
    chk("restart_dc_100", cic_y_o, 6400);

    acc_cnt   = 0;
    valid_cnt = 0;
    cyc       = 0;
    while (acc_cnt < 1500 && cyc < 30000) begin
      drive(0, 1, $urandom_range(0, 3) != 0, 12'($urandom));
      cyc++;
    end
    chk("random_accepts_reached", acc_cnt >= 1500, 1);
    for (int i = 0; i < 12; i++) drive(0, 1, 0, 0);
    chk("valid_count", valid_cnt, R * acc_cnt);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
